// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Define SERIAL_SUBTRACTOR_OVERFLOW_EN to build the signed-overflow flag; otherwise overflow is tied to 0.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             borrow_out_q, borrow_out_d;

    logic             ai, bi, di, br_next, last_bit;
    logic [WIDTH:0]   res_ext;
    logic [WIDTH-1:0] res_shift;

    assign ai       = a_q[0];
    assign bi       = b_q[0];
    assign di       = ai ^ bi ^ borrow_q;
    assign br_next  = (~ai & bi) | (~(ai ^ bi) & borrow_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    // Widened by one bit so the MSB-side shift-in also works for WIDTH=1.
    assign res_ext   = {di, res_q};
    assign res_shift = res_ext[WIDTH:1];

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        diff_d       = diff_q;
        cnt_d        = cnt_q;
        borrow_d     = borrow_q;
        borrow_out_d = borrow_out_q;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = borrow_in;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                res_d    = res_shift;
                borrow_d = br_next;
                cnt_d    = cnt_q + CW'(1);
                if (last_bit) begin
                    diff_d       = res_shift;
                    borrow_out_d = br_next;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            diff_q       <= diff_d;
            cnt_q        <= cnt_d;
            borrow_q     <= borrow_d;
            borrow_out_q <= borrow_out_d;
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic ovf_q;

    // Borrow into the MSB is the borrow register while the last bit is processed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == S_RUN && last_bit) begin
            ovf_q <= borrow_q ^ br_next;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign start_ready  = (state_q == S_IDLE);
    assign result_valid = (state_q == S_DONE);
    assign diff         = diff_q;
    assign borrow_out   = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=8): directed vector table, handshake corner
// sequences and randomized operations checked against an arithmetic model.
module tb_serial_subtractor;
    localparam int W = 8;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         borrow_in;
    logic         result_valid;
    logic         result_ready;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a            (a_in),
        .b            (b_in),
        .borrow_in    (borrow_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .diff         (diff),
        .borrow_out   (borrow_out),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;   // value when the overflow feature is built
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                  output logic [W-1:0] d, output logic bo, output logic ov);
        int u;
        int s;
        logic [31:0] uv;
        u  = int'(a) - int'(b) - int'(bin);
        uv = u;
        d  = uv[W-1:0];
        bo = (u < 0);
        s  = int'($signed(a)) - int'($signed(b)) - int'(bin);
        ov = OVF_EN && (s < -(1 << (W - 1)) || s > (1 << (W - 1)) - 1);
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        @(negedge clk);
        chk("start_ready_before_accept", start_ready, 1);
        a_in        = a;
        b_in        = b;
        borrow_in   = bin;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    // Waits for result_valid, scrambling the inputs (and start_valid) meanwhile.
    task automatic wait_done();
        int n;
        n = 0;
        while (!result_valid && n < 40) begin
            a_in        = W'($urandom);
            b_in        = W'($urandom);
            borrow_in   = 1'($urandom);
            start_valid = 1'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        start_valid = 1'b0;
        chk("latency", n, W);
        chk("start_ready_in_done", start_ready, 0);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] d, input logic bo,
                                input logic ov);
        chk({tag, "_diff"}, diff, d);
        chk({tag, "_borrow_out"}, borrow_out, bo);
        chk({tag, "_overflow"}, overflow, ov);
    endtask

    task automatic handoff();
        @(negedge clk);
        start_valid  = 1'b0;
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        chk("result_valid_after_handoff", result_valid, 0);
        chk("start_ready_after_handoff", start_ready, 1);
    endtask

    initial begin
        vec_t         vecs[6];
        logic [W-1:0] ed;
        logic         ebo;
        logic         eov;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'hF0, 8'h0F, 1'b0, 8'hE1, 1'b0, 1'b0};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};

        rst_n        = 1'b0;
        start_valid  = 1'b0;
        result_ready = 1'b0;
        a_in         = '0;
        b_in         = '0;
        borrow_in    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_start_ready", start_ready, 1);
        chk("reset_result_valid", result_valid, 0);
        check_result("reset", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
            wait_done();
            check_result($sformatf("vec%0d", i), vecs[i].d, vecs[i].bo, vecs[i].ov & OVF_EN);
            handoff();
        end

        // Backpressure: result must hold and new operands must be ignored.
        start_op(8'h10, 8'h04, 1'b0);
        wait_done();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start_valid = 1'b1;
            a_in        = 8'hA5 + W'(k);
            b_in        = 8'h3C;
            @(posedge clk);
            #1;
            chk("bp_result_valid", result_valid, 1);
            chk("bp_start_ready", start_ready, 0);
            check_result("bp", 8'h0C, 1'b0, 1'b0);
        end
        handoff();
        chk("bp_no_new_run", result_valid, 0);

        // Reset on the third RUN edge aborts the operation.
        start_op(8'h33, 8'h11, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_start_ready", start_ready, 1);
        chk("midrst_result_valid", result_valid, 0);
        check_result("midrst", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            chk("midrst_no_result", result_valid, 0);
        end
        start_op(8'h10, 8'h10, 1'b1);
        wait_done();
        check_result("after_rst", 8'hFF, 1'b1, 1'b0);
        handoff();

        // Randomized operations with random consumer stalls.
        for (int r = 0; r < 40; r++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rbin;
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            model(ra, rb, rbin, ed, ebo, eov);
            start_op(ra, rb, rbin);
            wait_done();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            check_result($sformatf("rand%0d", r), ed, ebo, eov);
            handoff();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
